dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
// - Shares the single data_mem port between the MEM-stage pipeline access and an external
//   debug/loader port (program load, memory inspection).
// - Sits between MEM_stage and data_mem. The pipeline has priority; a debug request is
//   served in idle cycles.
// - If the debug request is starved, the arbiter forces one pipeline stall cycle and serves
//   the debug access in that cycle.
// PARAMETERS
// - STARVE_LIMIT  default 8  debug blocked cycles before a forced stall; legal range 1..255
// - WAIT_W        default 8  width of the starvation counter; must hold STARVE_LIMIT
// PORTS
// - clk          in   1   system clock, rising edge
// - rst          in   1   synchronous reset, active-high
// - pipe_valid   in   1   MEM stage needs the port this cycle (load or store)
// - pipe_addr    in   16  pipeline address (ex_alu_result)
// - pipe_we      in   1   pipeline write enable
// - pipe_wdata   in   16  pipeline write data
// - pipe_rdata   out  16  read data to MEM stage; equals mem_rdata (combinational pass-through)
// - pipe_stall   out  1   registered; MEM stage holds its inputs and register this cycle
// - dbg_req      in   1   debug request; held high until dbg_ack
// - dbg_we       in   1   debug write enable; stable while dbg_req is high
// - dbg_addr     in   16  debug address; stable while dbg_req is high
// - dbg_wdata    in   16  debug write data; stable while dbg_req is high
// - dbg_ack      out  1   one-cycle completion pulse, registered
// - dbg_rdata    out  16  registered read data; valid while dbg_ack=1, held afterwards
// - mem_addr     out  16  to data_mem
// - mem_we       out  1   to data_mem
// - mem_wdata    out  16  to data_mem
// - mem_rdata    in   16  from data_mem; combinational read, synchronous write
// BEHAVIOUR
// - States: IDLE, STALL, ACK. Reset -> IDLE with pipe_stall=0, dbg_ack=0, dbg_rdata=0,
//   wait_cnt=0. mem_we is forced to 0 while rst=1.
// - Grant (combinational):
//   - debug has the port when (IDLE && dbg_req && !pipe_valid) || STALL;
//   - otherwise the pipeline has the port;
//   - mem_we = granted requester's we (pipe_we&pipe_valid or dbg_we).
// - IDLE, dbg_req && !pipe_valid: opportunistic grant; latch dbg_rdata<=mem_rdata;
//   wait_cnt<=0; next state ACK.
// - IDLE, dbg_req && pipe_valid:
//   - wait_cnt+1 saturating;
//   - if wait_cnt==STARVE_LIMIT-1, next state STALL (pipe_stall=1 next cycle).
// - IDLE, !dbg_req: wait_cnt<=0.
// - STALL: pipe_stall=1 for exactly this cycle. Debug granted regardless of pipe_valid;
//   latch dbg_rdata; wait_cnt<=0; next state ACK.
// - ACK: dbg_ack=1 for one cycle. The pipeline owns the port. dbg_req is ignored.
//   Next state IDLE. Minimum debug op spacing is 2 cycles (grant, ack).
// - Latency: debug access takes 2 cycles when uncontended. Worst case is
//   STARVE_LIMIT+2 cycles from dbg_req rise to dbg_ack.
// - Debug write is committed at the end of its grant cycle. A read in the same grant
//   returns the pre-write memory contents.
// - dbg_req dropping before ack: protocol violation. Behaviour is defined anyway: an
//   already-scheduled STALL and ACK still complete.
// - rst mid-operation: returns to IDLE next edge. A pending STALL or ACK is discarded and
//   no write is issued in the reset cycle.
// - No width conversion; all data and address paths are 16 bits.
// CONFIGURATION
// - DMEM_ARB_STATS_EN defined:
//   - adds outputs stat_dbg_grants[15:0] and stat_forced_stalls[15:0];
//   - both are free-running, wrap at 16'hFFFF->0, and reset to 0;
//   - grants count +1 per debug grant cycle; stalls count +1 per STALL cycle.
// - Undefined: the ports and counters are absent, and behaviour is otherwise identical.
// TESTING
// - Idle pipe, dbg write 0x0010<=0xBEEF, then dbg read 0x0010
//   -> mem_we=1 in grant cycle; acks 2 cycles apart; dbg_rdata=0xBEEF.
// - pipe_valid=1 continuously, dbg_req rises at cycle 0, STARVE_LIMIT=8
//   -> pipe_stall=1 only at cycle 8; dbg_ack=1 at cycle 9; pipe owns port at cycle 9.
// - Pipe store 0x0020<=0x1234 while dbg_req pending with pipe_valid=1
//   -> mem port carries pipe values; dbg_ack stays 0 until starvation or an idle cycle.
// - dbg_req held across ACK with pipe idle
//   -> grant, ack, grant, ack; never two grants in consecutive cycles.
// - rst asserted in the STALL cycle
//   -> next cycle pipe_stall=0, dbg_ack=0, dbg_rdata=0; memory at dbg_addr is unchanged.
// - DMEM_ARB_STATS_EN, 3 debug ops of which 1 is forced
//   -> stat_dbg_grants=3, stat_forced_stalls=1.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Shares the data memory port between the MEM-stage pipeline and a debug/loader port.
// Optional statistics counters are enabled with the DMEM_ARB_STATS_EN macro.
module dmem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned WAIT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [15:0] pipe_addr,
  input  logic        pipe_we,
  input  logic [15:0] pipe_wdata,
  output logic [15:0] pipe_rdata,
  output logic        pipe_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [15:0] dbg_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0] stat_dbg_grants,
  output logic [15:0] stat_forced_stalls
`endif
);

  localparam int unsigned DATA_W = 16;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STARVE_LIMIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = {WAIT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WAIT_W-1:0]   w_wait_cnt_next;
  logic                w_dbg_gnt;
  logic                r_pipe_stall;
  logic                r_dbg_ack;
  logic [DATA_W-1:0]   r_dbg_rdata;

  // Next-state, starvation counter and debug grant
  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_dbg_gnt       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (dbg_req && !pipe_valid) begin
          w_dbg_gnt       = 1'b1;
          w_wait_cnt_next = '0;
          w_state_next    = ST_ACK;
        end else if (dbg_req) begin
          if (r_wait_cnt != WAIT_MAX) begin
            w_wait_cnt_next = r_wait_cnt + WAIT_W'(1);
          end
          if (r_wait_cnt == WAIT_LAST) begin
            w_state_next = ST_STALL;
          end
        end else begin
          w_wait_cnt_next = '0;
        end
      end
      ST_STALL: begin
        w_dbg_gnt       = 1'b1;
        w_wait_cnt_next = '0;
        w_state_next    = ST_ACK;
      end
      ST_ACK: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Stall and ack are decoded from the next state so they line up with STALL/ACK
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_wait_cnt   <= '0;
      r_pipe_stall <= 1'b0;
      r_dbg_ack    <= 1'b0;
      r_dbg_rdata  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_wait_cnt   <= w_wait_cnt_next;
      r_pipe_stall <= (w_state_next == ST_STALL);
      r_dbg_ack    <= (w_state_next == ST_ACK);
      if (w_dbg_gnt) begin
        r_dbg_rdata <= mem_rdata;
      end
    end
  end

  // Memory port mux; no write may escape during reset
  assign mem_addr   = w_dbg_gnt ? dbg_addr  : pipe_addr;
  assign mem_wdata  = w_dbg_gnt ? dbg_wdata : pipe_wdata;
  assign mem_we     = !rst && (w_dbg_gnt ? dbg_we : (pipe_we && pipe_valid));
  assign pipe_rdata = mem_rdata;
  assign pipe_stall = r_pipe_stall;
  assign dbg_ack    = r_dbg_ack;
  assign dbg_rdata  = r_dbg_rdata;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_stat_grants;
  logic [15:0] r_stat_stalls;

  // Free-running wrap-around statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_grants <= '0;
      r_stat_stalls <= '0;
    end else begin
      if (w_dbg_gnt) begin
        r_stat_grants <= r_stat_grants + 16'(1);
      end
      if (r_state == ST_STALL) begin
        r_stat_stalls <= r_stat_stalls + 16'(1);
      end
    end
  end

  assign stat_dbg_grants    = r_stat_grants;
  assign stat_forced_stalls = r_stat_stalls;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: directed corner cases plus randomized contention.
// Build with DMEM_ARB_STATS_EN defined to also check the statistics counters.
module tb_dmem_port_arbiter;

  localparam int unsigned LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [15:0] pipe_addr;
  logic        pipe_we;
  logic [15:0] pipe_wdata;
  logic [15:0] pipe_rdata;
  logic        pipe_stall;
  logic        dbg_req;
  logic        dbg_we;
  logic [15:0] dbg_addr;
  logic [15:0] dbg_wdata;
  logic        dbg_ack;
  logic [15:0] dbg_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_dbg_grants;
  logic [15:0] stat_forced_stalls;
`endif

  always #5 clk = ~clk;

  dmem_port_arbiter #(.STARVE_LIMIT(LIMIT), .WAIT_W(8)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_addr(pipe_addr), .pipe_we(pipe_we),
    .pipe_wdata(pipe_wdata), .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_dbg_grants(stat_dbg_grants), .stat_forced_stalls(stat_forced_stalls)
`endif
  );

  // Data memory: combinational read, synchronous write
  logic [15:0] mem [0:65535];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        known;
    logic [15:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] dbg_ref [logic [15:0]];
  logic [15:0] pipe_ref [logic [15:0]];
  int          checks = 0;
  int          errors = 0;
  int          ops_issued = 0;
  int          stalls_seen = 0;
  bit          rand_done = 1'b0;
  int          busy_pct = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Start a debug op: expected read data is memory content before this op's write
  task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wd);
    exp_t e;
    e.known = dbg_ref.exists(addr) ? 1'b1 : 1'b0;
    e.val   = e.known ? dbg_ref[addr] : 16'h0;
    exp_q.push_back(e);
    if (we) dbg_ref[addr] = wd;
    ops_issued++;
    dbg_req   = 1'b1;
    dbg_we    = we;
    dbg_addr  = addr;
    dbg_wdata = wd;
  endtask

  task automatic wait_ack(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < int'(LIMIT) + 4) begin
      @(posedge clk); #1;
      n++;
      if (dbg_ack) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: no dbg_ack within %0d cycles (cycle %0d)", n, cyc);
    end
  endtask

  // Full debug op; the worst-case bound is one cycle longer if started during an ACK
  task automatic dbg_op(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                        output int lat);
    bit ok;
    bit in_ack;
    in_ack = dbg_ack;
    issue(we, addr, wd);
    wait_ack(lat, ok);
    if (ok) chk("dbg_latency_bound", 32'(lat <= (in_ack ? int'(LIMIT) + 2 : int'(LIMIT) + 1)), 32'd1);
    else exp_q.delete();
    dbg_req = 1'b0;
  endtask

  initial begin
    int  n;
    bit  ok;
    rst = 1'b1;
    pipe_valid = 1'b0; pipe_addr = '0; pipe_we = 1'b0; pipe_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    fork
      begin : monitor
        exp_t e;
        bit   prev_ack;
        bit   prev_stall;
        prev_ack = 1'b0;
        prev_stall = 1'b0;
        forever begin
          @(negedge clk);
          if (rst) begin
            chk("mem_we_in_reset", 32'(mem_we), 32'd0);
            stalls_seen = 0;
            prev_ack = 1'b0;
            prev_stall = 1'b0;
            continue;
          end
          if (dbg_ack) begin
            chk("ack_not_back_to_back", 32'(prev_ack), 32'd0);
            if (exp_q.size() == 0) begin
              chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              if (e.known) chk("dbg_rdata", 32'(dbg_rdata), 32'(e.val));
            end
          end
          if (pipe_stall) begin
            chk("stall_single_cycle", 32'(prev_stall), 32'd0);
            chk("stall_dbg_owns_port", 32'(mem_addr), 32'(dbg_addr));
            stalls_seen++;
          end
          if (pipe_valid && !pipe_stall) begin
            chk("pipe_owns_addr", 32'(mem_addr), 32'(pipe_addr));
            chk("pipe_owns_we", 32'(mem_we), 32'(pipe_we));
            if (pipe_we) begin
              chk("pipe_owns_wdata", 32'(mem_wdata), 32'(pipe_wdata));
              pipe_ref[pipe_addr] = pipe_wdata;
            end else if (pipe_ref.exists(pipe_addr)) begin
              chk("pipe_rdata", 32'(pipe_rdata), 32'(pipe_ref[pipe_addr]));
            end
          end
          prev_ack = dbg_ack;
          prev_stall = pipe_stall;
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_pipe_stall", 32'(pipe_stall), 32'd0);
    chk("reset_dbg_ack", 32'(dbg_ack), 32'd0);
    chk("reset_dbg_rdata", 32'(dbg_rdata), 32'd0);

    // Idle pipe: debug write then back-to-back read with request held across ACK
    issue(1'b1, 16'h0010, 16'hBEEF);
    @(negedge clk);
    chk("dbg_wr_mem_we", 32'(mem_we), 32'd1);
    chk("dbg_wr_mem_addr", 32'(mem_addr), 32'h0010);
    chk("dbg_wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    wait_ack(n, ok);
    chk("uncontended_latency", 32'(n), 32'd1);
    issue(1'b0, 16'h0010, 16'h0000);
    wait_ack(n, ok);
    chk("held_req_ack_spacing", 32'(n), 32'd2);
    dbg_req = 1'b0;
    chk("dbg_read_beef", 32'(dbg_rdata), 32'hBEEF);
    @(posedge clk); #1;
    chk("dbg_rdata_held", 32'(dbg_rdata), 32'hBEEF);
    chk("no_spurious_ack", 32'(dbg_ack), 32'd0);

    // Continuous pipe traffic (store then loads): forced stall exactly at cycle LIMIT
    pipe_valid = 1'b1; pipe_we = 1'b1; pipe_addr = 16'h0020; pipe_wdata = 16'h1234;
    issue(1'b0, 16'h0010, 16'h0000);
    for (int c = 0; c <= int'(LIMIT) + 2; c++) begin
      @(negedge clk);
      chk("starve_stall_timing", 32'(pipe_stall), 32'(c == int'(LIMIT)));
      chk("starve_ack_timing", 32'(dbg_ack), 32'(c == int'(LIMIT) + 1));
      if (c == int'(LIMIT) + 1) chk("pipe_owns_in_ack", 32'(mem_addr), 32'h0020);
      @(posedge clk); #1;
      pipe_we = 1'b0;
      if (c == int'(LIMIT) + 1) dbg_req = 1'b0;
    end
    pipe_valid = 1'b0;

    // Reset during a forced stall discards the pending debug write
    dbg_op(1'b1, 16'h0040, 16'h1111, n);
    dbg_op(1'b0, 16'h0010, 16'h0000, n);
    @(posedge clk); #1;
    pipe_valid = 1'b1; pipe_we = 1'b0; pipe_addr = 16'h0020;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0040; dbg_wdata = 16'h5555;
    n = 0;
    while (!pipe_stall && n < int'(LIMIT) + 3) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_reached", 32'(pipe_stall), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_stall_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    chk("rst_pipe_stall", 32'(pipe_stall), 32'd0);
    chk("rst_dbg_ack", 32'(dbg_ack), 32'd0);
    chk("rst_dbg_rdata", 32'(dbg_rdata), 32'd0);
    chk("rst_mem_unchanged", 32'(mem[16'h0040]), 32'h1111);
    rst = 1'b0; dbg_req = 1'b0; pipe_valid = 1'b0;
    ops_issued = 0;

    // Three debug ops, one of them forced by starvation
    dbg_op(1'b1, 16'h8001, 16'hA5A5, n);
    dbg_op(1'b0, 16'h8001, 16'h0000, n);
    @(posedge clk); #1;
    pipe_valid = 1'b1; pipe_we = 1'b0; pipe_addr = 16'h0020;
    dbg_op(1'b0, 16'h8001, 16'h0000, n);
    chk("forced_latency", 32'(n), 32'(LIMIT + 1));
    pipe_valid = 1'b0;
    @(posedge clk); #1;
`ifdef DMEM_ARB_STATS_EN
    chk("stat_dbg_grants_3", 32'(stat_dbg_grants), 32'd3);
    chk("stat_forced_stalls_1", 32'(stat_forced_stalls), 32'd1);
`endif

    // Randomized contention at three pipeline load levels
    fork
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          pipe_valid = ($urandom_range(99) < busy_pct);
          pipe_we    = 1'($urandom_range(1));
          pipe_addr  = {11'h000, 5'($urandom)};
          pipe_wdata = 16'($urandom);
        end
        pipe_valid = 1'b0;
      end
      begin
        for (int ph = 0; ph < 3; ph++) begin
          busy_pct = (ph == 0) ? 30 : ((ph == 1) ? 100 : 85);
          for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(2)) begin
              @(posedge clk); #1;
            end
            dbg_op(1'($urandom_range(1)), {12'h800, 4'($urandom)}, 16'($urandom), n);
          end
        end
        rand_done = 1'b1;
      end
    join

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
`ifdef DMEM_ARB_STATS_EN
    chk("stat_dbg_grants_total", 32'(stat_dbg_grants), 32'(ops_issued));
    chk("stat_forced_stalls_total", 32'(stat_forced_stalls), 32'(stalls_seen));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
